// File: rtl/qarma64_pkg.sv
// Shared QARMA-64 constants: cell geometry and the ShuffleCells permutations.
// The round pipeline stages import this package so every stage agrees on the
// cell layout (cell k = bits [4k+3:4k]) and on tau / tau^-1.
package qarma64_pkg;

   localparam int CELL_W  = 4;
   localparam int NCELLS  = 16;
   localparam int STATE_W = CELL_W * NCELLS;

   // Output cell i takes input cell TAU[i] (forward rounds).
   localparam int TAU [NCELLS] = '{
      0, 11, 6, 13, 10, 1, 12, 7, 5, 14, 3, 8, 15, 4, 9, 2
   };

   // Output cell i takes input cell TAU_INV[i] (backward rounds).
   localparam int TAU_INV [NCELLS] = '{
      0, 5, 15, 10, 13, 8, 2, 7, 11, 14, 4, 1, 6, 3, 9, 12
   };

   // Extract one 4-bit cell from a 64-bit state.
   function automatic logic [CELL_W-1:0] cell_of(input logic [STATE_W-1:0] s,
                                                 input int idx);
      return s[CELL_W*idx +: CELL_W];
   endfunction

endpackage

// File: rtl/cell_permute.sv
// Combinational ShuffleCells permutation: tau when inv=0, tau^-1 when inv=1.
// Pure wiring after synthesis; the mux on inv is the only logic.
module cell_permute
   import qarma64_pkg::*;
(
   input  logic [STATE_W-1:0] state,
   input  logic               inv,
   output logic [STATE_W-1:0] permuted
);

   // Route every output cell from its source cell selected by direction.
   always_comb begin
      permuted = '0;
      for (int i = 0; i < NCELLS; i++) begin
         if (inv)
            permuted[CELL_W*i +: CELL_W] = cell_of(state, TAU_INV[i]);
         else
            permuted[CELL_W*i +: CELL_W] = cell_of(state, TAU[i]);
      end
   end

endmodule

// File: rtl/shuffle_cells_stage.sv
// QARMA-64 ShuffleCells pipeline stage.
// The state is permuted on the way in and parked in a 2-entry in-order FIFO
// (head + tail registers). in_ready is a register so the upstream handshake
// never sees a combinational path from out_ready. Outputs come straight from
// the head registers, giving one cycle of latency and full throughput.
module shuffle_cells_stage
   import qarma64_pkg::*;
#(
   parameter int TAG_W = 5
)
(
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [STATE_W-1:0] in_state,
   input  logic               in_inv,
   input  logic [TAG_W-1:0]   in_tag,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [STATE_W-1:0] out_state,
   output logic               out_inv,
   output logic [TAG_W-1:0]   out_tag,
   output logic [1:0]         occupancy
);

   // FIFO fill states; encoding equals the entry count.
   localparam logic [1:0] ST_EMPTY = 2'd0;
   localparam logic [1:0] ST_ONE   = 2'd1;
   localparam logic [1:0] ST_FULL  = 2'd2;

   logic [1:0]         fill;
   logic [1:0]         fill_next;
   logic               ready_q;
   logic               push;
   logic               pop;

   logic [STATE_W-1:0] perm_state;

   logic [STATE_W-1:0] head_state;
   logic               head_inv;
   logic [TAG_W-1:0]   head_tag;
   logic [STATE_W-1:0] tail_state;
   logic               tail_inv;
   logic [TAG_W-1:0]   tail_tag;

   cell_permute u_permute (
      .state    (in_state),
      .inv      (in_inv),
      .permuted (perm_state)
   );

   // Handshakes; ready_q is already 0 while in FULL, so no overwrite is possible.
   assign push      = in_valid && ready_q;
   assign pop       = out_valid && out_ready;

   assign in_ready  = ready_q;
   assign out_valid = (fill != ST_EMPTY);
   assign out_state = head_state;
   assign out_inv   = head_inv;
   assign out_tag   = head_tag;
   assign occupancy = fill;

   // Next fill state from the push/pop combination.
   always_comb begin
      fill_next = fill;
      case (fill)
         ST_EMPTY: begin
            if (push)
               fill_next = ST_ONE;
         end
         ST_ONE: begin
            if (push && !pop)
               fill_next = ST_FULL;
            else if (pop && !push)
               fill_next = ST_EMPTY;
         end
         ST_FULL: begin
            if (pop)
               fill_next = ST_ONE;
         end
         default: fill_next = ST_EMPTY;
      endcase
   end

   // Control registers: fill state and the registered ready flag.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill    <= ST_EMPTY;
         ready_q <= 1'b0;
      end else begin
         fill    <= fill_next;
         ready_q <= (fill_next != ST_FULL);
      end
   end

   // Head entry: loaded from the permuter when it is (or becomes) the only
   // entry, or promoted from the tail when the head drains out of FULL.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head_state <= '0;
         head_inv   <= 1'b0;
         head_tag   <= '0;
      end else if ((fill == ST_EMPTY && push) || (fill == ST_ONE && push && pop)) begin
         head_state <= perm_state;
         head_inv   <= in_inv;
         head_tag   <= in_tag;
      end else if (fill == ST_FULL && pop) begin
         head_state <= tail_state;
         head_inv   <= tail_inv;
         head_tag   <= tail_tag;
      end
   end

   // Tail entry: only written when a push lands behind a head that stays.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         tail_state <= '0;
         tail_inv   <= 1'b0;
         tail_tag   <= '0;
      end else if (fill == ST_ONE && push && !pop) begin
         tail_state <= perm_state;
         tail_inv   <= in_inv;
         tail_tag   <= in_tag;
      end
   end

endmodule

// File: tb/tb_shuffle_cells_stage.sv
// Directed bench for shuffle_cells_stage: reference vectors, round trip,
// backpressure, streaming and mid-stream reset.
module tb_shuffle_cells_stage;

   localparam int TAG_W = 5;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [63:0]      in_state;
   logic             in_inv;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [63:0]      out_state;
   logic             out_inv;
   logic [TAG_W-1:0] out_tag;
   logic [1:0]       occupancy;

   int checks;
   int failures;

   localparam logic [63:0] VEC_IN  = 64'hFEDCBA9876543210;
   localparam logic [63:0] VEC_FWD = 64'h294F83E57C1AD6B0;
   localparam logic [63:0] VEC_INV = 64'hC93614EB728DAF50;

   shuffle_cells_stage #(.TAG_W(TAG_W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_state  (in_state),
      .in_inv    (in_inv),
      .in_tag    (in_tag),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_state (out_state),
      .out_inv   (out_inv),
      .out_tag   (out_tag),
      .occupancy (occupancy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock; inputs and samples both sit 1ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [63:0] s;
      logic [63:0] fwd;
      checks   = 0;
      failures = 0;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_state  = '0;
      in_inv    = 1'b0;
      in_tag    = '0;
      out_ready = 1'b0;

      // Reset state
      step();
      step();
      check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst_occ",       {62'd0, occupancy}, 64'd0);
      check_eq("rst_in_ready",  {63'd0, in_ready}, 64'd0);
      check_eq("rst_out_state", out_state, 64'd0);
      rst_n = 1'b1;
      step();
      check_eq("rel_in_ready",  {63'd0, in_ready}, 64'd1);

      // Forward reference vector
      in_valid = 1'b1; in_state = VEC_IN; in_inv = 1'b0; in_tag = 5'd3;
      step();
      in_valid = 1'b0;
      check_eq("fwd_valid", {63'd0, out_valid}, 64'd1);
      check_eq("fwd_state", out_state, VEC_FWD);
      check_eq("fwd_tag",   {59'd0, out_tag}, 64'd3);
      check_eq("fwd_inv",   {63'd0, out_inv}, 64'd0);
      check_eq("fwd_occ",   {62'd0, occupancy}, 64'd1);
      out_ready = 1'b1;
      step();
      check_eq("fwd_drain_occ", {62'd0, occupancy}, 64'd0);

      // Inverse reference vector
      in_valid = 1'b1; in_state = VEC_IN; in_inv = 1'b1; in_tag = 5'd7;
      step();
      in_valid = 1'b0;
      check_eq("inv_state", out_state, VEC_INV);
      check_eq("inv_inv",   {63'd0, out_inv}, 64'd1);
      check_eq("inv_tag",   {59'd0, out_tag}, 64'd7);
      step();
      check_eq("inv_drain_valid", {63'd0, out_valid}, 64'd0);

      // Round trip: forward then inverse must restore the original state
      for (int n = 0; n < 1000; n++) begin
         s = {$urandom(), $urandom()};
         in_valid = 1'b1; in_state = s; in_inv = 1'b0; in_tag = 5'(n);
         step();
         fwd = out_state;
         in_state = fwd; in_inv = 1'b1;
         step();
         in_valid = 1'b0;
         check_eq("roundtrip", out_state, s);
         step();
      end
      check_eq("roundtrip_occ", {62'd0, occupancy}, 64'd0);

      // Backpressure: three offers with out_ready low, only two fit
      out_ready = 1'b0;
      in_valid = 1'b1; in_state = VEC_IN; in_inv = 1'b0; in_tag = 5'd1;
      step();
      check_eq("bp_occ1",   {62'd0, occupancy}, 64'd1);
      check_eq("bp_rdy1",   {63'd0, in_ready}, 64'd1);
      in_state = VEC_IN; in_inv = 1'b1; in_tag = 5'd2;
      step();
      check_eq("bp_occ2",   {62'd0, occupancy}, 64'd2);
      check_eq("bp_rdy2",   {63'd0, in_ready}, 64'd0);
      in_state = 64'h0123456789ABCDEF; in_inv = 1'b0; in_tag = 5'd9;
      step();
      check_eq("bp_occ3",   {62'd0, occupancy}, 64'd2);
      check_eq("bp_hold_tag",   {59'd0, out_tag}, 64'd1);
      check_eq("bp_hold_state", out_state, VEC_FWD);
      in_valid = 1'b0;
      out_ready = 1'b1;
      step();
      check_eq("bp_pop1_tag",   {59'd0, out_tag}, 64'd2);
      check_eq("bp_pop1_state", out_state, VEC_INV);
      check_eq("bp_pop1_occ",   {62'd0, occupancy}, 64'd1);
      step();
      check_eq("bp_empty_valid", {63'd0, out_valid}, 64'd0);
      check_eq("bp_empty_rdy",   {63'd0, in_ready}, 64'd1);

      // Streaming: one transaction per cycle, tags come out in order
      for (int t = 0; t < 20; t++) begin
         in_valid = 1'b1; in_state = VEC_IN; in_inv = t[0]; in_tag = 5'(t);
         step();
         check_eq("stream_tag", {59'd0, out_tag}, 64'(t));
         check_eq("stream_occ", {62'd0, occupancy}, 64'd1);
         check_eq("stream_state", out_state, t[0] ? VEC_INV : VEC_FWD);
      end
      in_valid = 1'b0;
      step();
      check_eq("stream_end_occ", {62'd0, occupancy}, 64'd0);

      // Reset while full
      out_ready = 1'b0;
      in_valid = 1'b1; in_state = VEC_IN; in_inv = 1'b1; in_tag = 5'd11;
      step();
      in_tag = 5'd12;
      step();
      in_valid = 1'b0;
      check_eq("mid_full_occ", {62'd0, occupancy}, 64'd2);
      rst_n = 1'b0;
      step();
      check_eq("mid_rst_valid", {63'd0, out_valid}, 64'd0);
      check_eq("mid_rst_occ",   {62'd0, occupancy}, 64'd0);
      check_eq("mid_rst_state", out_state, 64'd0);
      check_eq("mid_rst_tag",   {59'd0, out_tag}, 64'd0);
      check_eq("mid_rst_inv",   {63'd0, out_inv}, 64'd0);
      rst_n = 1'b1;
      step();
      check_eq("mid_rel_rdy",   {63'd0, in_ready}, 64'd1);
      in_valid = 1'b1; in_state = VEC_IN; in_inv = 1'b0; in_tag = 5'd3;
      step();
      in_valid = 1'b0;
      check_eq("mid_post_state", out_state, VEC_FWD);
      check_eq("mid_post_tag",   {59'd0, out_tag}, 64'd3);
      check_eq("mid_post_occ",   {62'd0, occupancy}, 64'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
